mux_arb_n: RTL and testbench

//  Parametrised successor to the 2:1 gate-level mux: N-channel, WIDTH-bit registered

---
 rtl/mux_arb_n.sv | 134 +++++++++++++
 tb/tb_mux_arb_n.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_arb_n.sv
// mux_arb_n: N-channel, WIDTH-bit registered multiplexer with valid/ready on every
// input and on the output. Selection is either a fixed channel index (mode=0, sel)
// or round-robin arbitration (mode=1) starting after the last granted channel.
// Optional feature macro: MUX_ARB_LOCK_EN adds a `lock` input that pins the grant
// to the channel of the most recent transfer while lock is high.
module mux_arb_n #(
   parameter int WIDTH = 8,
   parameter int N     = 4,
   parameter int SELW  = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N*WIDTH-1:0]   in_data,
   input  logic [N-1:0]         in_valid,
   output logic [N-1:0]         in_ready,
   input  logic                 mode,
   input  logic [SELW-1:0]      sel,
`ifdef MUX_ARB_LOCK_EN
   input  logic                 lock,
`endif
   output logic [WIDTH-1:0]     out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [SELW-1:0]      out_chan
);

   logic [N-1:0]      base_grant;
   logic [N-1:0]      grant;
   logic              rr_found;
   logic [SELW-1:0]   grant_chan;
   logic [WIDTH-1:0]  grant_data;
   logic              any_grant;
   logic              load;
   logic [SELW-1:0]   rr_ptr;

   // The output register can accept a new word when it is empty or being drained now
   assign load      = !out_valid || out_ready;
   assign any_grant = |grant;

   // Pick the candidate channel: direct index in fixed mode, first valid after rr_ptr otherwise
   always_comb begin
      base_grant = '0;
      rr_found   = 1'b0;
      if (!mode) begin
         for (int i = 0; i < N; i++) begin
            if (sel == SELW'(i)) begin
               base_grant[i] = in_valid[i];
            end
         end
      end else begin
         for (int k = 1; k <= N; k++) begin
            for (int i = 0; i < N; i++) begin
               if (!rr_found && in_valid[i] && (i == ((int'(rr_ptr) + k) % N))) begin
                  base_grant[i] = 1'b1;
                  rr_found      = 1'b1;
               end
            end
         end
      end
   end

`ifdef MUX_ARB_LOCK_EN
   logic lock_held;

   // While locked, only the channel that supplied the last word may be granted
   always_comb begin
      grant = base_grant;
      if (lock && lock_held) begin
         grant = '0;
         for (int i = 0; i < N; i++) begin
            if (out_chan == SELW'(i)) begin
               grant[i] = in_valid[i];
            end
         end
      end
   end

   // A lock holder exists only once some transfer has happened since reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lock_held <= 1'b0;
      end else if (load && any_grant) begin
         lock_held <= 1'b1;
      end
   end
`else
   // Without the lock feature the candidate grant is final
   always_comb begin
      grant = base_grant;
   end
`endif

   // Encode the one-hot grant into a channel index and select that channel's data
   always_comb begin
      grant_chan = '0;
      grant_data = '0;
      for (int i = 0; i < N; i++) begin
         if (grant[i]) begin
            grant_chan = SELW'(i);
            grant_data = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   // Accept only from the granted channel, and never while reset is asserted
   always_comb begin
      in_ready = '0;
      if (rst_n && load) begin
         in_ready = grant;
      end
   end

   // Output register and round-robin pointer; a stalled output holds its word
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_chan  <= '0;
         rr_ptr    <= SELW'(N - 1);
      end else if (load) begin
         if (any_grant) begin
            out_valid <= 1'b1;
            out_data  <= grant_data;
            out_chan  <= grant_chan;
            if (mode) begin
               rr_ptr <= grant_chan;
            end
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mux_arb_n.sv
// tb_mux_arb_n: scenario tasks for mux_arb_n (reset, fixed select, round-robin,
// back-pressure, sparse round-robin, lock, reset mid-transfer). Expected words are
// queued when a transfer is driven and compared when the output word is consumed.
module tb_mux_arb_n;

   localparam int WIDTH = 8;
   localparam int N     = 4;
   localparam int SELW  = 2;

   logic               clk;
   logic               rst_n;
   logic [N*WIDTH-1:0] in_data;
   logic [N-1:0]       in_valid;
   logic [N-1:0]       in_ready;
   logic               mode;
   logic [SELW-1:0]    sel;
   logic [WIDTH-1:0]   out_data;
   logic               out_valid;
   logic               out_ready;
   logic [SELW-1:0]    out_chan;
`ifdef MUX_ARB_LOCK_EN
   logic               lock;
`endif

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic [SELW-1:0]  chan;
   } exp_t;

   exp_t sb[$];
   exp_t exp_w;
   int   n_checks = 0;
   int   n_fail   = 0;

   mux_arb_n #(.WIDTH(WIDTH), .N(N), .SELW(SELW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mode      (mode),
      .sel       (sel),
`ifdef MUX_ARB_LOCK_EN
      .lock      (lock),
`endif
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_chan  (out_chan)
   );

   // Free-running clock, 10 time units per period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [WIDTH-1:0] ch_data(input int c);
      case (c)
         0:       return 8'h11;
         1:       return 8'h22;
         2:       return 8'hA5;
         default: return 8'h44;
      endcase
   endfunction

   function automatic exp_t mk_exp(input int c);
      return exp_t'({ch_data(c), SELW'(c)});
   endfunction

   task automatic test_reset();
      rst_n     = 1'b0;
      in_data   = {8'h44, 8'hA5, 8'h22, 8'h11};
      in_valid  = 4'b1111;
      mode      = 1'b1;
      sel       = '0;
      out_ready = 1'b1;
`ifdef MUX_ARB_LOCK_EN
      lock      = 1'b0;
`endif
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b required 0", out_valid); end
      n_checks++;
      if (out_data !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_data: got %h required 00", out_data); end
      n_checks++;
      if (out_chan !== 2'd0) begin n_fail++; $display("[TB] FAIL reset_chan: got %0d required 0", out_chan); end
      n_checks++;
      if (in_ready !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_in_ready: got %b required 0000", in_ready); end
   endtask

   task automatic test_fixed();
      logic [SELW-1:0] sel_tab   [5] = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd0};
      logic [N-1:0]    valid_tab [5] = '{4'b1111, 4'b1111, 4'b1111, 4'b1101, 4'b0000};
      logic [N-1:0]    ready_tab [5] = '{4'b0100, 4'b1000, 4'b0001, 4'b0000, 4'b0000};
      int              chan_tab  [5] = '{2, 3, 0, 1, 0};
      for (int t = 0; t < 6; t++) begin
         @(negedge clk);
         rst_n     = 1'b1;
         mode      = 1'b0;
         out_ready = 1'b1;
         if (t < 5) begin
            sel      = sel_tab[t];
            in_valid = valid_tab[t];
         end
         #1;
         if (out_valid && out_ready) begin
            n_checks++;
            if (sb.size() == 0) begin
               n_fail++; $display("[TB] FAIL fixed_word: got %h/%0d required none", out_data, out_chan);
            end else begin
               exp_w = sb.pop_front();
               if ({out_data, out_chan} !== exp_w) begin
                  n_fail++; $display("[TB] FAIL fixed_word: got %h/%0d required %h/%0d", out_data, out_chan, exp_w.data, exp_w.chan);
               end
            end
         end
         if (t < 5) begin
            n_checks++;
            if (in_ready !== ready_tab[t]) begin
               n_fail++; $display("[TB] FAIL fixed_in_ready[%0d]: got %b required %b", t, in_ready, ready_tab[t]);
            end
            if (ready_tab[t] != '0) sb.push_back(mk_exp(chan_tab[t]));
         end
      end
      n_checks++;
      if (out_valid !== 1'b0 || sb.size() != 0) begin
         n_fail++; $display("[TB] FAIL fixed_drain: got valid=%b pending=%0d required valid=0 pending=0", out_valid, sb.size());
      end
   endtask

   task automatic test_round_robin();
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         mode      = 1'b1;
         out_ready = 1'b1;
         in_valid  = (c < 8) ? 4'b1111 : 4'b0000;
         #1;
         if (out_valid && out_ready) begin
            n_checks++;
            if (sb.size() == 0) begin
               n_fail++; $display("[TB] FAIL rr_word: got %h/%0d required none", out_data, out_chan);
            end else begin
               exp_w = sb.pop_front();
               if ({out_data, out_chan} !== exp_w) begin
                  n_fail++; $display("[TB] FAIL rr_word: got %h/%0d required %h/%0d", out_data, out_chan, exp_w.data, exp_w.chan);
               end
            end
         end
         if (c < 8) begin
            n_checks++;
            if (in_ready !== (4'b0001 << (c % 4))) begin
               n_fail++; $display("[TB] FAIL rr_in_ready[%0d]: got %b required %b", c, in_ready, 4'b0001 << (c % 4));
            end
            sb.push_back(mk_exp(c % 4));
         end
      end
      n_checks++;
      if (out_valid !== 1'b0 || sb.size() != 0) begin
         n_fail++; $display("[TB] FAIL rr_drain: got valid=%b pending=%0d required valid=0 pending=0", out_valid, sb.size());
      end
   endtask

   task automatic test_back_pressure();
      // cycle 0 loads ch0, cycles 1..3 stall, cycle 4 drains ch0 and loads ch1, cycle 5 drains ch1
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         mode      = 1'b1;
         in_valid  = (c < 5) ? 4'b1111 : 4'b0000;
         out_ready = (c >= 1 && c <= 3) ? 1'b0 : 1'b1;
         #1;
         if (out_valid && out_ready) begin
            n_checks++;
            if (sb.size() == 0) begin
               n_fail++; $display("[TB] FAIL bp_word: got %h/%0d required none", out_data, out_chan);
            end else begin
               exp_w = sb.pop_front();
               if ({out_data, out_chan} !== exp_w) begin
                  n_fail++; $display("[TB] FAIL bp_word: got %h/%0d required %h/%0d", out_data, out_chan, exp_w.data, exp_w.chan);
               end
            end
         end
         if (c >= 1 && c <= 3) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h11 || out_chan !== 2'd0 || in_ready !== 4'b0000) begin
               n_fail++; $display("[TB] FAIL bp_stall[%0d]: got v=%b d=%h ch=%0d rdy=%b required v=1 d=11 ch=0 rdy=0000", c, out_valid, out_data, out_chan, in_ready);
            end
         end
         if (c == 0 || c == 4) begin
            n_checks++;
            if (in_ready !== ((c == 0) ? 4'b0001 : 4'b0010)) begin
               n_fail++; $display("[TB] FAIL bp_in_ready[%0d]: got %b required %b", c, in_ready, (c == 0) ? 4'b0001 : 4'b0010);
            end
            sb.push_back(mk_exp((c == 0) ? 0 : 1));
         end
      end
      n_checks++;
      if (out_valid !== 1'b0 || sb.size() != 0) begin
         n_fail++; $display("[TB] FAIL bp_drain: got valid=%b pending=%0d required valid=0 pending=0", out_valid, sb.size());
      end
   endtask

   task automatic test_sparse_rr();
      // Pointer sits at 1 after the previous scenario, so ch3 wins first
      int chan_tab [4] = '{3, 1, 3, 1};
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         mode      = 1'b1;
         out_ready = 1'b1;
         in_valid  = (c < 4) ? 4'b1010 : 4'b0000;
         #1;
         if (out_valid && out_ready) begin
            n_checks++;
            if (sb.size() == 0) begin
               n_fail++; $display("[TB] FAIL sparse_word: got %h/%0d required none", out_data, out_chan);
            end else begin
               exp_w = sb.pop_front();
               if ({out_data, out_chan} !== exp_w) begin
                  n_fail++; $display("[TB] FAIL sparse_word: got %h/%0d required %h/%0d", out_data, out_chan, exp_w.data, exp_w.chan);
               end
            end
         end
         if (c < 4) begin
            n_checks++;
            if (in_ready !== (4'b0001 << chan_tab[c])) begin
               n_fail++; $display("[TB] FAIL sparse_in_ready[%0d]: got %b required %b", c, in_ready, 4'b0001 << chan_tab[c]);
            end
            sb.push_back(mk_exp(chan_tab[c]));
         end
      end
      n_checks++;
      if (out_valid !== 1'b0 || sb.size() != 0) begin
         n_fail++; $display("[TB] FAIL sparse_drain: got valid=%b pending=%0d required valid=0 pending=0", out_valid, sb.size());
      end
   endtask

`ifdef MUX_ARB_LOCK_EN
   task automatic test_lock();
      // ch2 first (pointer at 1), then held by lock for 3 cycles, then 3, 0
      int chan_tab [6] = '{2, 2, 2, 2, 3, 0};
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         mode      = 1'b1;
         out_ready = 1'b1;
         in_valid  = (c < 6) ? 4'b1111 : 4'b0000;
         lock      = (c >= 1 && c <= 3);
         #1;
         if (out_valid && out_ready) begin
            n_checks++;
            if (sb.size() == 0) begin
               n_fail++; $display("[TB] FAIL lock_word: got %h/%0d required none", out_data, out_chan);
            end else begin
               exp_w = sb.pop_front();
               if ({out_data, out_chan} !== exp_w) begin
                  n_fail++; $display("[TB] FAIL lock_word: got %h/%0d required %h/%0d", out_data, out_chan, exp_w.data, exp_w.chan);
               end
            end
         end
         if (c < 6) begin
            n_checks++;
            if (in_ready !== (4'b0001 << chan_tab[c])) begin
               n_fail++; $display("[TB] FAIL lock_in_ready[%0d]: got %b required %b", c, in_ready, 4'b0001 << chan_tab[c]);
            end
            sb.push_back(mk_exp(chan_tab[c]));
         end
      end
      lock = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0 || sb.size() != 0) begin
         n_fail++; $display("[TB] FAIL lock_drain: got valid=%b pending=%0d required valid=0 pending=0", out_valid, sb.size());
      end
   endtask
`endif

   task automatic test_reset_mid_transfer();
      @(negedge clk);
      mode      = 1'b0;
      sel       = 2'd1;
      in_valid  = 4'b0010;
      out_ready = 1'b0;
      #1;
      n_checks++;
      if (in_ready !== 4'b0010) begin n_fail++; $display("[TB] FAIL midrst_in_ready: got %b required 0010", in_ready); end
      @(negedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h22) begin
         n_fail++; $display("[TB] FAIL midrst_held: got v=%b d=%h required v=1 d=22", out_valid, out_data);
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (in_ready !== 4'b0000) begin n_fail++; $display("[TB] FAIL midrst_ready_low: got %b required 0000", in_ready); end
      @(negedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || out_chan !== 2'd0) begin
         n_fail++; $display("[TB] FAIL midrst_discard: got v=%b d=%h ch=%0d required v=0 d=00 ch=0", out_valid, out_data, out_chan);
      end
      rst_n    = 1'b1;
      in_valid = 4'b0000;
   endtask

   // Run every scenario in order, then report
   initial begin
      $display("[TB] starting mux_arb_n scenarios");
      test_reset();
      test_fixed();
      test_round_robin();
      test_back_pressure();
      test_sparse_rr();
`ifdef MUX_ARB_LOCK_EN
      test_lock();
`endif
      test_reset_mid_transfer();
      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
